// File: rtl/matrix_serializer_if.sv
// Stream bundle for matrix_serializer: wide matrix input stream plus narrow element output stream.
// slave modport is the serializer side, master modport is the producer/consumer side.
interface matrix_serializer_if #(
    parameter int MAT_WIDTH    = 4,
    parameter int MAT_HEIGHT   = 4,
    parameter int ELEMENT_SIZE = 32
);
    logic [MAT_WIDTH*MAT_HEIGHT*ELEMENT_SIZE-1:0] s_axis_tdata;
    logic                                         s_axis_tvalid;
    logic                                         s_axis_tlast;
    logic                                         s_axis_tuser;
    logic                                         s_axis_tready;
    logic [ELEMENT_SIZE-1:0]                      m_axis_tdata;
    logic                                         m_axis_tvalid;
    logic                                         m_axis_tready;
    logic                                         m_axis_tlast;
    logic                                         m_axis_tuser;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/matrix_serializer.sv
// Serializes one full matrix per input beat into one element per output beat.
// Optional macro SERIALIZE_COL_MAJOR_EN selects column-major emission order (default row-major).
module matrix_serializer #(
    parameter int MAT_WIDTH    = 4,
    parameter int MAT_HEIGHT   = 4,
    parameter int ELEMENT_SIZE = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    matrix_serializer_if.slave bus
);
    localparam int N     = MAT_WIDTH * MAT_HEIGHT;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                        state_reg;
    logic [IDX_W-1:0]              index_reg;
    logic [N*ELEMENT_SIZE-1:0]     matrix_reg;
    logic                          tvalid_reg;
    logic                          tlast_reg;
    logic                          tuser_reg;
    logic [IDX_W-1:0]              index_next;
    logic [ELEMENT_SIZE-1:0]       ordered [N];
    logic                          unused_tlast;

    // Input tlast carries no information: each matrix is already one output packet.
    assign unused_tlast = bus.s_axis_tlast;
    assign index_next   = index_reg + 1'b1;

    // Static reorder of the matrix register into emission sequence order.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_order
`ifdef SERIALIZE_COL_MAJOR_EN
            localparam int SRC = (gi % MAT_HEIGHT) * MAT_WIDTH + (gi / MAT_HEIGHT);
`else
            localparam int SRC = gi;
`endif
            assign ordered[gi] = matrix_reg[SRC*ELEMENT_SIZE +: ELEMENT_SIZE];
        end
    endgenerate

    assign bus.m_axis_tdata  = ordered[index_reg];
    assign bus.m_axis_tvalid = tvalid_reg;
    assign bus.m_axis_tlast  = tlast_reg;
    assign bus.m_axis_tuser  = tuser_reg;
    assign bus.s_axis_tready = reset_n &
                               ((state_reg == IDLE) ||
                                ((state_reg == SEND) && tlast_reg && bus.m_axis_tready));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            index_reg  <= '0;
            matrix_reg <= '0;
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
            tuser_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.s_axis_tvalid) begin
                        matrix_reg <= bus.s_axis_tdata;
                        tuser_reg  <= bus.s_axis_tuser;
                        index_reg  <= '0;
                        tvalid_reg <= 1'b1;
                        tlast_reg  <= (LAST_IDX == '0);
                        state_reg  <= SEND;
                    end
                end
                SEND: begin
                    if (bus.m_axis_tready) begin
                        if (!tlast_reg) begin
                            index_reg <= index_next;
                            tlast_reg <= (index_next == LAST_IDX);
                        end else if (bus.s_axis_tvalid) begin
                            // Final beat and next matrix share a cycle: no bubble between packets.
                            matrix_reg <= bus.s_axis_tdata;
                            tuser_reg  <= bus.s_axis_tuser;
                            index_reg  <= '0;
                            tlast_reg  <= (LAST_IDX == '0);
                        end else begin
                            index_reg  <= '0;
                            tvalid_reg <= 1'b0;
                            tlast_reg  <= 1'b0;
                            state_reg  <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_serializer.sv
// Directed self-checking bench for matrix_serializer (4x4, 32-bit elements).
module tb_matrix_serializer;
    localparam int W = 4;
    localparam int H = 4;
    localparam int E = 32;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    matrix_serializer_if #(.MAT_WIDTH(W), .MAT_HEIGHT(H), .ELEMENT_SIZE(E)) ifc ();

    matrix_serializer #(.MAT_WIDTH(W), .MAT_HEIGHT(H), .ELEMENT_SIZE(E)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    always #5 clk = ~clk;

    function automatic logic [N*E-1:0] make_mat(input logic [31:0] base);
        logic [N*E-1:0] m;
        for (int k = 0; k < N; k++) m[k*E +: E] = base + 32'(k);
        return m;
    endfunction

    // Expected element at output sequence position i.
    function automatic logic [31:0] exp_elem(input logic [31:0] base, input int i);
        int k;
`ifdef SERIALIZE_COL_MAJOR_EN
        k = (i % H) * W + (i / H);
`else
        k = i;
`endif
        return base + 32'(k);
    endfunction

    task automatic test_reset();
        #1;
        checks++; if (ifc.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b want 0", ifc.m_axis_tvalid); end
        checks++; if (ifc.s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b want 0", ifc.s_axis_tready); end
        checks++; if (ifc.m_axis_tdata !== 32'h0) begin errors++; $display("FAIL rst_tdata got %h want 0", ifc.m_axis_tdata); end
        checks++; if (ifc.m_axis_tlast !== 1'b0 || ifc.m_axis_tuser !== 1'b0) begin errors++; $display("FAIL rst_last_user got %b%b want 00", ifc.m_axis_tlast, ifc.m_axis_tuser); end
        @(posedge clk); #1; reset_n = 1'b1; #1;
        checks++; if (ifc.s_axis_tready !== 1'b1) begin errors++; $display("FAIL idle_tready got %b want 1", ifc.s_axis_tready); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        ifc.s_axis_tdata = make_mat(32'hA000_0000); ifc.s_axis_tvalid = 1'b1; ifc.m_axis_tready = 1'b1;
        @(posedge clk); #1; ifc.s_axis_tvalid = 1'b0;
        for (int i = 0; i < N; i++) begin
            #1;
            checks++; if (ifc.m_axis_tvalid !== 1'b1 || ifc.m_axis_tdata !== exp_elem(32'hA000_0000, i) || ifc.m_axis_tlast !== (i == N-1))
                begin errors++; $display("FAIL single_beat%0d got v%b %h l%b want v1 %h l%b", i, ifc.m_axis_tvalid, ifc.m_axis_tdata, ifc.m_axis_tlast, exp_elem(32'hA000_0000, i), (i == N-1)); end
            checks++; if (ifc.s_axis_tready !== (i == N-1)) begin errors++; $display("FAIL single_tready%0d got %b want %b", i, ifc.s_axis_tready, (i == N-1)); end
            @(posedge clk); #1;
        end
        #1;
        checks++; if (ifc.m_axis_tvalid !== 1'b0 || ifc.s_axis_tready !== 1'b1) begin errors++; $display("FAIL single_end got v%b r%b want v0 r1", ifc.m_axis_tvalid, ifc.s_axis_tready); end
        $display("test_single 16 beats checked");
    endtask

    task automatic test_backpressure();
        int beat = 0;
        int cyc = 0;
        logic stall_prev = 1'b0;
        logic [31:0] d_prev = '0;
        logic l_prev = 1'b0;
        ifc.s_axis_tdata = make_mat(32'hA000_0000); ifc.s_axis_tvalid = 1'b1; ifc.m_axis_tready = 1'b1;
        @(posedge clk); #1; ifc.s_axis_tvalid = 1'b0;
        while (beat < N && cyc < 80) begin
            ifc.m_axis_tready = (cyc % 2 == 0); #1;
            if (ifc.m_axis_tvalid) begin
                checks++; if (ifc.m_axis_tdata !== exp_elem(32'hA000_0000, beat) || ifc.m_axis_tlast !== (beat == N-1))
                    begin errors++; $display("FAIL bp_beat%0d got %h l%b want %h l%b", beat, ifc.m_axis_tdata, ifc.m_axis_tlast, exp_elem(32'hA000_0000, beat), (beat == N-1)); end
                if (stall_prev) begin
                    checks++; if (ifc.m_axis_tdata !== d_prev || ifc.m_axis_tlast !== l_prev)
                        begin errors++; $display("FAIL bp_hold%0d got %h l%b want %h l%b", beat, ifc.m_axis_tdata, ifc.m_axis_tlast, d_prev, l_prev); end
                end
                if (ifc.m_axis_tready) beat++;
            end
            stall_prev = ifc.m_axis_tvalid && !ifc.m_axis_tready;
            d_prev = ifc.m_axis_tdata; l_prev = ifc.m_axis_tlast;
            @(posedge clk); #1; cyc++;
        end
        ifc.m_axis_tready = 1'b1; #1;
        checks++; if (beat != N || cyc != 2*N-1) begin errors++; $display("FAIL bp_count got beats %0d cycles %0d want %0d %0d", beat, cyc, N, 2*N-1); end
        checks++; if (ifc.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL bp_extra got v%b want 0", ifc.m_axis_tvalid); end
        $display("test_backpressure %0d beats in %0d cycles", beat, cyc);
    endtask

    task automatic test_back_to_back();
        logic [31:0] base;
        ifc.s_axis_tdata = make_mat(32'hB000_0000); ifc.s_axis_tuser = 1'b1; ifc.s_axis_tvalid = 1'b1; ifc.m_axis_tready = 1'b1;
        @(posedge clk); #1;
        ifc.s_axis_tdata = make_mat(32'hC000_0000); ifc.s_axis_tuser = 1'b0;
        for (int i = 0; i < 2*N; i++) begin
            #1;
            base = (i < N) ? 32'hB000_0000 : 32'hC000_0000;
            checks++; if (ifc.m_axis_tvalid !== 1'b1 || ifc.m_axis_tdata !== exp_elem(base, i % N) || ifc.m_axis_tlast !== (i % N == N-1))
                begin errors++; $display("FAIL b2b_beat%0d got v%b %h l%b want v1 %h l%b", i, ifc.m_axis_tvalid, ifc.m_axis_tdata, ifc.m_axis_tlast, exp_elem(base, i % N), (i % N == N-1)); end
            checks++; if (ifc.m_axis_tuser !== (i < N)) begin errors++; $display("FAIL b2b_tuser%0d got %b want %b", i, ifc.m_axis_tuser, (i < N)); end
            if (i == N-1) begin
                checks++; if (ifc.s_axis_tready !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b want 1", ifc.s_axis_tready); end
            end
            @(posedge clk); #1;
            if (i == N-1) ifc.s_axis_tvalid = 1'b0;
        end
        #1;
        checks++; if (ifc.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL b2b_end got v%b want 0", ifc.m_axis_tvalid); end
        $display("test_back_to_back 32 beats checked");
    endtask

    task automatic test_reset_midstream();
        ifc.s_axis_tdata = make_mat(32'hA000_0000); ifc.s_axis_tuser = 1'b1; ifc.s_axis_tvalid = 1'b1; ifc.m_axis_tready = 1'b1;
        @(posedge clk); #1; ifc.s_axis_tvalid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0; #1;
        checks++; if (ifc.m_axis_tvalid !== 1'b0 || ifc.m_axis_tdata !== 32'h0 || ifc.s_axis_tready !== 1'b0)
            begin errors++; $display("FAIL mid_rst got v%b %h r%b want v0 0 r0", ifc.m_axis_tvalid, ifc.m_axis_tdata, ifc.s_axis_tready); end
        @(posedge clk); @(posedge clk); #1;
        checks++; if (ifc.m_axis_tvalid !== 1'b0 || ifc.s_axis_tready !== 1'b0) begin errors++; $display("FAIL mid_rst_hold got v%b r%b want v0 r0", ifc.m_axis_tvalid, ifc.s_axis_tready); end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ifc.m_axis_tvalid !== 1'b0 || ifc.s_axis_tready !== 1'b1) begin errors++; $display("FAIL post_rst%0d got v%b r%b want v0 r1", i, ifc.m_axis_tvalid, ifc.s_axis_tready); end
            @(posedge clk); #1;
        end
        ifc.s_axis_tdata = make_mat(32'hD000_0000); ifc.s_axis_tuser = 1'b0; ifc.s_axis_tvalid = 1'b1;
        @(posedge clk); #1; ifc.s_axis_tvalid = 1'b0;
        for (int i = 0; i < N; i++) begin
            #1;
            checks++; if (ifc.m_axis_tvalid !== 1'b1 || ifc.m_axis_tdata !== exp_elem(32'hD000_0000, i) || ifc.m_axis_tlast !== (i == N-1) || ifc.m_axis_tuser !== 1'b0)
                begin errors++; $display("FAIL restart_beat%0d got v%b %h l%b u%b want v1 %h l%b u0", i, ifc.m_axis_tvalid, ifc.m_axis_tdata, ifc.m_axis_tlast, ifc.m_axis_tuser, exp_elem(32'hD000_0000, i), (i == N-1)); end
            @(posedge clk); #1;
        end
        $display("test_reset_midstream done");
    endtask

    initial begin
        ifc.s_axis_tdata = '0; ifc.s_axis_tvalid = 1'b0; ifc.s_axis_tlast = 1'b1;
        ifc.s_axis_tuser = 1'b0; ifc.m_axis_tready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/matrix_serializer.md
Name: matrix_serializer

Overview:
Consumes one full complex matrix per AXI-Stream beat on the wide parallel bus used by scalar_divide and the other matrix ops. Emits it one element per beat on a narrow AXI-Stream output. It is the downstream end of the parallel matrix interface and feeds element-serial consumers (DMA, UART/result dump, FFT front end). Elements carry a 16-bit signed real part in the low half and a 16-bit signed imaginary part in the high half; the block treats them as opaque ELEMENT_SIZE words.

Parameters:
MAT_WIDTH, 4, columns per matrix
MAT_HEIGHT, 4, rows per matrix
ELEMENT_SIZE, 32, bits per element (real in low half, imaginary in high half; passed through unmodified)

Ports:
clk  in  1  clock; all logic on its rising edge
reset_n  in  1  asynchronous, active-low reset
s_axis_tdata  in  MAT_WIDTH*MAT_HEIGHT*ELEMENT_SIZE  matrix; element k=r*MAT_WIDTH+c at bits [k*ELEMENT_SIZE +: ELEMENT_SIZE]
s_axis_tvalid  in  1  input matrix valid
s_axis_tlast  in  1  accepted and ignored (each matrix is one output packet)
s_axis_tuser  in  1  sideband flag, captured with the matrix
s_axis_tready  out  1  block can accept a matrix this cycle
m_axis_tdata  out  ELEMENT_SIZE  current element
m_axis_tvalid  out  1  element valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  final element of the matrix
m_axis_tuser  out  1  captured s_axis_tuser of the matrix being sent

Behaviour:
- N = MAT_WIDTH*MAT_HEIGHT. Index counter width = clog2(N), minimum 1.
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, index=0, matrix register=0, state=IDLE. s_axis_tready is forced to 0 while reset_n is low.
- Reset takes effect immediately, asynchronously, mid-matrix. The in-flight matrix is discarded. No partial beats are emitted after release.
- States: IDLE, SEND.
- IDLE:
  - s_axis_tready=1 and m_axis_tvalid=0.
  - On s_axis_tvalid: capture tdata and tuser, set index=0, go to SEND.
- SEND:
  - m_axis_tvalid=1 and m_axis_tdata = element[index].
  - m_axis_tlast = (index==N-1). m_axis_tuser = the captured flag.
- On an output handshake (tvalid & tready) with index<N-1: index+1.
- On an output handshake with index==N-1:
  - If s_axis_tvalid is also high, the next matrix is captured in the same cycle, index=0, and the block stays in SEND.
  - Otherwise go to IDLE.
- s_axis_tready = IDLE, or (SEND & index==N-1 & m_axis_tready). Sustained throughput is N cycles per matrix with no bubble.
- Latency: first element is valid on the cycle after the input handshake.
- While m_axis_tvalid is high and m_axis_tready is low, tdata, tlast and tuser hold stable. No element is dropped or duplicated.
- m_axis_tdata is driven from a registered index into the registered matrix (mux after the flops is allowed). The matrix register only loads on an input handshake.
- N==1: every beat has tlast=1, and s_axis_tready follows m_axis_tready while in SEND.

Optional Feature:
SERIALIZE_COL_MAJOR_EN
- Defined: elements are emitted in column-major order, k = c*MAT_HEIGHT + r in sequence, i.e. element index r*MAT_WIDTH+c with r fastest. This gives transposed output order for column-oriented consumers.
- Undefined: row-major order, element 0..N-1.
- tlast, tuser, handshake and timing are identical in both builds.

Test Plan:
- Single matrix, 4x4, element k = 32'hA000_0000+k, m_axis_tready=1. Required response:
  - Beats on 16 consecutive cycles starting one cycle after acceptance, tdata A000_0000..A000_000F.
  - tlast only on the beat with A000_000F.
  - s_axis_tready=0 during the first 15 beats.
- Backpressure: same matrix, m_axis_tready toggles 1,0,1,0. Required response:
  - Exactly 16 beats in order over about 32 cycles.
  - tdata/tlast stable on every cycle with valid=1 and ready=0.
- Back-to-back: matrix B (elements 32'hB000_0000+k) then C (32'hC000_0000+k), both valid continuously, ready=1. Required response:
  - C is accepted on B's tlast cycle.
  - 32 beats on 32 consecutive cycles; tlast at beats 15 and 31.
- Sideband: B with s_axis_tuser=1, then C with tuser=0. Required response: m_axis_tuser=1 on all 16 B beats and 0 on all 16 C beats.
- Reset mid-stream: assert reset_n=0 after beat 5 (tdata A000_0005). Required response:
  - m_axis_tvalid=0 without waiting for a clock edge; m_axis_tdata=0 and s_axis_tready=0 while reset is low.
  - After release: s_axis_tready=1, no beats until a new matrix arrives; a new matrix starts at element 0.
- With SERIALIZE_COL_MAJOR_EN, matrix A. Required response: tdata low nibbles in order 0,4,8,C,1,5,9,D,2,6,A,E,3,7,B,F, with tlast on F.
